muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit with a parametrised operand width.
- Sits beside the single-cycle ALU in the execute stage.
- Accepts one operation through a valid/ready handshake and computes it in a shift-add or restoring-division loop, one bit per cycle.
- Holds the result until the core takes it, and produces the same zero flag as the ALU.

---
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle; XLEN+1 edges from accept to out_valid, 1 edge for div-by-zero/overflow.
// in_ready only in IDLE; the result is held in DONE until out_ready, and requests arriving while busy are ignored.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] input1,
    input  logic [XLEN-1:0] input2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   m_q, hi_q, lo_q, result_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              zero_q;

    logic              accept, last_step;
    logic              sgn1, sgn2, div_zero, div_ovf, fast;
    logic [XLEN-1:0]   mag1, mag2, fast_res;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   hi_step, lo_step, div_sel, div_res, calc_res;
    logic [2*XLEN-1:0] prod, prod_res;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign accept    = in_valid & in_ready;
    assign last_step = (cnt_q == CNT_W'(1));

    // Operand decode at acceptance: magnitudes plus the early-out cases that skip CALC.
    always_comb begin
        sgn1     = input1[XLEN-1] & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
        sgn2     = input2[XLEN-1] & (op == 3'b001 || op == 3'b100 || op == 3'b110);
        mag1     = sgn1 ? -input1 : input1;
        mag2     = sgn2 ? -input2 : input2;
        div_zero = op[2] & (input2 == '0);
        div_ovf  = op[2] & ~op[0] & (input1 == MIN_NEG) & (&input2);
        fast     = div_zero | div_ovf;
        if (div_zero) begin
            fast_res = op[1] ? input1 : '1;
        end else begin
            fast_res = op[1] ? '0 : MIN_NEG;
        end
    end

    // hi/lo double as product {hi,lo} for multiply and {remainder,quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, m_q};
        if (op_q[2]) begin
            hi_step = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod     = {hi_step, lo_step};
        prod_res = neg_q ? -prod : prod;
        div_sel  = op_q[1] ? hi_step : lo_step;
        div_res  = neg_q ? -div_sel : div_sel;
        if (op_q[2]) begin
            calc_res = div_res;
        end else if (op_q[1:0] == 2'b00) begin
            calc_res = prod_res[XLEN-1:0];
        end else begin
            calc_res = prod_res[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            op_q  <= op;
            // Remainder takes the dividend's sign; everything else the product of signs.
            neg_q <= (op[2] & op[1]) ? sgn1 : (sgn1 ^ sgn2);
            cnt_q <= CNT_W'(XLEN);
            hi_q  <= '0;
            lo_q  <= op[2] ? mag1 : mag2;
            m_q   <= op[2] ? mag2 : mag1;
            if (fast) begin
                result_q <= fast_res;
                zero_q   <= (fast_res == '0);
            end
        end else if (state == CALC) begin
            hi_q  <= hi_step;
            lo_q  <= lo_step;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_step) begin
                result_q <= calc_res;
                zero_q   <= (calc_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at XLEN=32 and XLEN=8 against an integer-arithmetic reference.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [2:0]  op;
    logic [31:0] in1, in2, result;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, busy8;
    logic [2:0]  op8;
    logic [7:0]  in1_8, in2_8, result8;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .input1(in1), .input2(in2), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    muldiv_unit #(.XLEN(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
        .input1(in1_8), .input2(in2_8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .zero(zero8), .busy(busy8)
    );

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    exp_t        cur[2];
    bit          prev_v[2];
    bit          have[2];
    bit          bp[2];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;

    logic        ov_a[2], or_a[2], zero_a[2], in_ready_a[2], busy_a[2];
    logic [31:0] res_a[2];
    assign ov_a[0] = out_valid;   assign ov_a[1] = out_valid8;
    assign or_a[0] = out_ready;   assign or_a[1] = out_ready8;
    assign zero_a[0] = zero;      assign zero_a[1] = zero8;
    assign in_ready_a[0] = in_ready; assign in_ready_a[1] = in_ready8;
    assign busy_a[0] = busy;      assign busy_a[1] = busy8;
    assign res_a[0] = result;     assign res_a[1] = {24'b0, result8};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: RV32M semantics on w-bit values using 64-bit signed/unsigned integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int w);
        longint one_w, ua, ub, sa, sb, r;
        logic [63:0] u;
        bit ovf;
        one_w = longint'(1) << w;
        ua = longint'({32'b0, a}) & (one_w - 1);
        ub = longint'({32'b0, b}) & (one_w - 1);
        sa = (ua >= one_w / 2) ? ua - one_w : ua;
        sb = (ub >= one_w / 2) ? ub - one_w : ub;
        ovf = (sa == -(one_w / 2)) && (sb == -1);
        case (o)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> w;
            3'd2: r = (sa * ub) >>> w;
            3'd3: begin u = ua * ub; r = longint'(u >> w); end
            3'd4: r = (ub == 0) ? -1 : (ovf ? sa : sa / sb);
            3'd5: r = (ub == 0) ? -1 : ua / ub;
            3'd6: r = (ub == 0) ? ua : (ovf ? 0 : sa % sb);
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(r & (one_w - 1));
    endfunction

    function automatic logic [31:0] ropnd(input int k);
        logic [31:0] m;
        m = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return m;
            2: return m ^ (m >> 1);
            3: return 32'($urandom_range(0, 15));
            default: return $urandom & m;
        endcase
    endfunction

    task automatic issue(input int k, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit track);
        int w, guard;
        logic [31:0] m, la, lb;
        exp_t e;
        w = (k == 0) ? 32 : 8;
        m = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        la = a & m;
        lb = b & m;
        guard = 0;
        @(negedge clk);
        while (!in_ready_a[k] && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready_a[k]) begin
            chk("issue_wait_in_ready", 32'(in_ready_a[k]), 1);
            return;
        end
        if (k == 0) begin
            in_valid = 1'b1; op = o; in1 = la; in2 = lb;
        end else begin
            in_valid8 = 1'b1; op8 = o; in1_8 = la[7:0]; in2_8 = lb[7:0];
        end
        @(posedge clk);
        #1;
        if (track) begin
            e.res = model(o, la, lb, w);
            e.acc = cyc;
            e.lat = (o[2] && (lb == 0 || (!o[0] && la == (m ^ (m >> 1)) && lb == m))) ? 1 : w + 1;
            if (k == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        // Operands change right after acceptance; the unit must have latched them.
        if (k == 0) begin
            in_valid = 1'b0; op = 3'($urandom); in1 = $urandom; in2 = $urandom;
        end else begin
            in_valid8 = 1'b0; op8 = 3'($urandom); in1_8 = 8'($urandom); in2_8 = 8'($urandom);
        end
    endtask

    // A one-edge request while busy; the unit cannot reach IDLE before in_valid drops again.
    task automatic pulse(input int k);
        @(negedge clk);
        if (busy_a[k]) begin
            if (k == 0) begin
                in_valid = 1'b1; op = 3'($urandom); in1 = $urandom; in2 = $urandom;
            end else begin
                in_valid8 = 1'b1; op8 = 3'($urandom); in1_8 = 8'($urandom); in2_8 = 8'($urandom);
            end
            @(negedge clk);
            in_valid = 1'b0;
            in_valid8 = 1'b0;
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        out_ready = 1'b0;
        out_ready8 = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            out_ready  = bp[0] ? 1'b0 : ($urandom_range(0, 2) != 0);
            out_ready8 = bp[1] ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                prev_v[k] = 1'b0;
            end else begin
                if (prev_v[k]) chk("valid_release", 32'(ov_a[k]), 32'(!or_a[k]));
                if (ov_a[k]) begin
                    if (!prev_v[k]) begin
                        have[k] = (k == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
                        chk("sb_pending", 32'(have[k]), 1);
                        if (have[k]) begin
                            if (k == 0) cur[k] = sb0.pop_front();
                            else        cur[k] = sb1.pop_front();
                            chk("result", res_a[k], cur[k].res);
                            chk("zero", 32'(zero_a[k]), 32'(cur[k].res == 0));
                            chk("latency", 32'(cyc - cur[k].acc + 1), 32'(cur[k].lat));
                        end
                    end else if (have[k]) begin
                        chk("hold_result", res_a[k], cur[k].res);
                        chk("hold_zero", 32'(zero_a[k]), 32'(cur[k].res == 0));
                    end
                end
                prev_v[k] = ov_a[k];
            end
        end
    end

    logic [2:0]  d_op [10] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b110, 3'b101, 3'b100, 3'b111, 3'b100, 3'b110};
    logic [31:0] d_a  [10] = '{32'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b  [10] = '{32'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                               32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        int g;
        rst = 1'b1;
        in_valid = 1'b0; op = '0; in1 = '0; in2 = '0;
        in_valid8 = 1'b0; op8 = '0; in1_8 = '0; in2_8 = '0;
        bp[0] = 1'b0; bp[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_result", result, 0);
        chk("reset_zero", 32'(zero), 0);
        chk("reset_busy", 32'(busy), 0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 1);
        chk("post_reset_in_ready8", 32'(in_ready8), 1);

        for (int i = 0; i < 10; i++) issue(0, d_op[i], d_a[i], d_b[i], 1'b1);

        // Reset in the middle of a divide: the operation vanishes without a result.
        issue(0, 3'b101, 32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        chk("mid_calc_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        repeat (40) @(negedge clk);
        chk("no_result_after_rst", 32'(out_valid), 0);

        // Backpressure: result parked for 10 cycles with requests hammering the unit.
        issue(0, 3'b000, $urandom, $urandom, 1'b1);
        bp[0] = 1'b1;
        repeat (3) pulse(0);
        g = 0;
        while (!out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("bp_out_valid", 32'(out_valid), 1);
        repeat (5) pulse(0);
        bp[0] = 1'b0;

        for (int i = 0; i < 150; i++) begin
            issue(0, 3'($urandom_range(0, 7)), ropnd(0), ropnd(0), 1'b1);
            if ($urandom_range(0, 3) == 0) pulse(0);
        end

        issue(1, 3'b010, 32'h80, 32'hFF, 1'b1);
        for (int i = 0; i < 100; i++) begin
            issue(1, 3'($urandom_range(0, 7)), ropnd(1), ropnd(1), 1'b1);
            if ($urandom_range(0, 3) == 0) pulse(1);
        end

        g = 0;
        while ((sb0.size() != 0 || sb1.size() != 0 || out_valid || out_valid8) && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("drain_pending", 32'(sb0.size() + sb1.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
